// File: rtl/bru_bp.sv
// Branch resolution unit with a bimodal predictor. It resolves jal, jalr and conditional
// branches into a registered result, and it owns the 2-bit counter table that the IFU reads.
module bru_bp #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned BHT_DEPTH = 16,
   parameter logic [1:0]  CNT_INIT  = 2'b01
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic [XLEN-1:0] i_ifu_pc,
   output logic            o_bht_taken,
   input  logic            i_bru_valid,
   output logic            o_bru_ready,
   input  logic [XLEN-1:0] i_bru_pc,
   input  logic [XLEN-1:0] i_idu_imm,
   input  logic [XLEN-1:0] i_bru_rs1_data,
   input  logic [XLEN-1:0] i_bru_rs2_data,
   input  logic            i_idu_jal,
   input  logic            i_idu_jalr,
   input  logic            i_idu_brch,
   input  logic [2:0]      i_idu_funct3,
   input  logic            i_bru_pred_taken,
   input  logic            i_bru_flush,
   output logic            o_bru_valid,
   input  logic            i_bru_ready,
   output logic [XLEN-1:0] o_bru_next_pc,
   output logic [XLEN-1:0] o_bru_link,
   output logic            o_bru_taken,
   output logic            o_bru_redirect,
   output logic            o_bru_err
);

   localparam int unsigned IdxW = $clog2(BHT_DEPTH);

   logic [1:0]      bht_q [BHT_DEPTH];
   logic [1:0]      bht_d [BHT_DEPTH];
   logic [IdxW-1:0] rd_idx, wr_idx;

   logic            valid_q, valid_d;
   logic [XLEN-1:0] next_pc_q, link_q;
   logic            taken_q, redirect_q, err_q;

   logic            accept;
   logic            is_jal, is_jalr, is_brch;
   logic            cond, f3_illegal, br_taken, taken, redirect, err, bht_upd;
   logic [XLEN-1:0] pc_imm, rs1_imm, pc4, target;

   assign rd_idx      = i_ifu_pc[IdxW+1:2];
   assign wr_idx      = i_bru_pc[IdxW+1:2];
   assign o_bht_taken = bht_q[rd_idx][1];

   assign o_bru_ready = ~valid_q | i_bru_ready;
   assign accept      = i_bru_valid & o_bru_ready & ~i_bru_flush;

   // Decode flags are made mutually exclusive so that jal > jalr > brch holds everywhere.
   assign is_jal  = i_idu_jal;
   assign is_jalr = ~i_idu_jal & i_idu_jalr;
   assign is_brch = ~i_idu_jal & ~i_idu_jalr & i_idu_brch;

   always_comb begin
      cond       = 1'b0;
      f3_illegal = 1'b0;
      case (i_idu_funct3)
         3'b000:  cond = (i_bru_rs1_data == i_bru_rs2_data);
         3'b001:  cond = (i_bru_rs1_data != i_bru_rs2_data);
         3'b100:  cond = ($signed(i_bru_rs1_data) <  $signed(i_bru_rs2_data));
         3'b101:  cond = ($signed(i_bru_rs1_data) >= $signed(i_bru_rs2_data));
         3'b110:  cond = (i_bru_rs1_data <  i_bru_rs2_data);
         3'b111:  cond = (i_bru_rs1_data >= i_bru_rs2_data);
         default: f3_illegal = 1'b1;
      endcase
   end

   assign pc_imm   = i_bru_pc + i_idu_imm;
   assign rs1_imm  = i_bru_rs1_data + i_idu_imm;
   assign pc4      = i_bru_pc + XLEN'(4);
   assign br_taken = is_brch & cond;
   assign taken    = is_jal | is_jalr | br_taken;

   always_comb begin
      target = pc4;
      if (is_jal)        target = pc_imm;
      else if (is_jalr)  target = {rs1_imm[XLEN-1:1], 1'b0};
      else if (br_taken) target = pc_imm;
   end

   // Unconditional jumps are not predicted, so the IFU always has to be steered to them.
   assign redirect = (is_jal | is_jalr) ? 1'b1 :
                     is_brch            ? (taken ^ i_bru_pred_taken) : i_bru_pred_taken;
   assign err      = (is_brch & f3_illegal) | (taken & target[1]);
   assign bht_upd  = accept & is_brch & ~f3_illegal;

   always_comb begin
      bht_d = bht_q;
      if (bht_upd) begin
         if (br_taken && bht_q[wr_idx] != 2'b11)      bht_d[wr_idx] = bht_q[wr_idx] + 2'b01;
         else if (!br_taken && bht_q[wr_idx] != 2'b00) bht_d[wr_idx] = bht_q[wr_idx] - 2'b01;
      end
   end

   always_comb begin
      valid_d = valid_q;
      if (i_bru_flush)      valid_d = 1'b0;
      else if (accept)      valid_d = 1'b1;
      else if (i_bru_ready) valid_d = 1'b0;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= CNT_INIT;
         valid_q    <= 1'b0;
         next_pc_q  <= '0;
         link_q     <= '0;
         taken_q    <= 1'b0;
         redirect_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         bht_q   <= bht_d;
         valid_q <= valid_d;
         if (accept) begin
            next_pc_q  <= target;
            link_q     <= pc4;
            taken_q    <= taken;
            redirect_q <= redirect;
            err_q      <= err;
         end
      end
   end

   assign o_bru_valid    = valid_q;
   assign o_bru_next_pc  = next_pc_q;
   assign o_bru_link     = link_q;
   assign o_bru_taken    = taken_q;
   assign o_bru_redirect = redirect_q;
   assign o_bru_err      = err_q;

endmodule

// File: tb/tb_bru_bp.sv
// Scenario bench for bru_bp: expected results are queued at issue and checked by a monitor
// when each result is handed off downstream.
module tb_bru_bp;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ifu_pc;
   logic        bht_taken;
   logic        bru_valid, bru_ready_o;
   logic [31:0] pc, imm, rs1, rs2;
   logic        jal, jalr, brch;
   logic [2:0]  f3;
   logic        pred, flush;
   logic        res_valid, res_ready;
   logic [31:0] next_pc, link;
   logic        taken, redirect, err;

   typedef struct packed {
      logic [31:0] npc;
      logic [31:0] link;
      logic        taken;
      logic        redirect;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   bru_bp dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_ifu_pc         (ifu_pc),
      .o_bht_taken      (bht_taken),
      .i_bru_valid      (bru_valid),
      .o_bru_ready      (bru_ready_o),
      .i_bru_pc         (pc),
      .i_idu_imm        (imm),
      .i_bru_rs1_data   (rs1),
      .i_bru_rs2_data   (rs2),
      .i_idu_jal        (jal),
      .i_idu_jalr       (jalr),
      .i_idu_brch       (brch),
      .i_idu_funct3     (f3),
      .i_bru_pred_taken (pred),
      .i_bru_flush      (flush),
      .o_bru_valid      (res_valid),
      .i_bru_ready      (res_ready),
      .o_bru_next_pc    (next_pc),
      .o_bru_link       (link),
      .o_bru_taken      (taken),
      .o_bru_redirect   (redirect),
      .o_bru_err        (err)
   );

   // A result is consumed at the next posedge when valid & ready; check it half a cycle earlier.
   always @(negedge clk) begin
      if (!rst && res_valid && res_ready) begin
         exp_t act, e;
         act = '{npc: next_pc, link: link, taken: taken, redirect: redirect, err: err};
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL result_unexpected: got %h with empty scoreboard", act);
         end else begin
            e = sb.pop_front();
            if (act !== e) begin
               failures++;
               $display("FAIL result: got npc=%h link=%h t=%b r=%b e=%b, want npc=%h link=%h t=%b r=%b e=%b",
                        act.npc, act.link, act.taken, act.redirect, act.err,
                        e.npc, e.link, e.taken, e.redirect, e.err);
            end
         end
      end
   end

   function automatic exp_t mk(input logic [31:0] n, input logic [31:0] l,
                               input logic t, input logic r, input logic e);
      mk = '{npc: n, link: l, taken: t, redirect: r, err: e};
   endfunction

   task automatic drive_req(input logic [31:0] p, input logic [31:0] im, input logic [31:0] a,
                            input logic [31:0] b, input logic j, input logic jr, input logic br,
                            input logic [2:0] fn, input logic pr);
      pc = p; imm = im; rs1 = a; rs2 = b; jal = j; jalr = jr; brch = br; f3 = fn; pred = pr;
      bru_valid = 1'b1;
   endtask

   task automatic end_req();
      bru_valid = 1'b0; jal = 1'b0; jalr = 1'b0; brch = 1'b0; pred = 1'b0; flush = 1'b0;
   endtask

   task automatic issue(input logic [31:0] p, input logic [31:0] im, input logic [31:0] a,
                        input logic [31:0] b, input logic j, input logic jr, input logic br,
                        input logic [2:0] fn, input logic pr, input exp_t e);
      drive_req(p, im, a, b, j, jr, br, fn, pr);
      sb.push_back(e);
      @(posedge clk); #1;
      end_req();
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic test_reset();
      rst = 1'b1; res_ready = 1'b0; ifu_pc = 32'h8000_0000;
      end_req(); pc = '0; imm = '0; rs1 = '0; rs2 = '0; f3 = '0;
      idle(2);
      checks++;
      if ({res_valid, next_pc, link, taken, redirect, err} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: valid=%b npc=%h link=%h t=%b r=%b e=%b, want all 0",
                  res_valid, next_pc, link, taken, redirect, err);
      end
      rst = 1'b0; res_ready = 1'b1;
      #1;
      checks++;
      if (bht_taken !== 1'b0) begin
         failures++; $display("FAIL reset_bht: got %b want 0", bht_taken);
      end
      checks++;
      if (bru_ready_o !== 1'b1) begin
         failures++; $display("FAIL reset_ready: got %b want 1", bru_ready_o);
      end
   endtask

   task automatic test_beq_first();
      ifu_pc = 32'h8000_0010;
      #1;
      checks++;
      if (bht_taken !== 1'b0) begin
         failures++; $display("FAIL beq_bht_before: got %b want 0", bht_taken);
      end
      issue(32'h8000_0010, 32'h20, 32'd5, 32'd5, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0,
            mk(32'h8000_0030, 32'h8000_0014, 1'b1, 1'b1, 1'b0));
      checks++;
      if (bht_taken !== 1'b1) begin
         failures++; $display("FAIL beq_bht_after: got %b want 1", bht_taken);
      end
      idle(1);
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 3; i++) begin
         issue(32'h8000_0010, 32'h20, 32'd9, 32'd9, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1,
               mk(32'h8000_0030, 32'h8000_0014, 1'b1, 1'b0, 1'b0));
         checks++;
         if (bht_taken !== 1'b1) begin
            failures++; $display("FAIL sat_taken_%0d: got %b want 1", i, bht_taken);
         end
      end
      issue(32'h8000_0010, 32'h20, 32'd5, 32'd6, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1,
            mk(32'h8000_0014, 32'h8000_0014, 1'b0, 1'b1, 1'b0));
      checks++;
      if (bht_taken !== 1'b1) begin
         failures++; $display("FAIL sat_nt_once: got %b want 1", bht_taken);
      end
      idle(1);
   endtask

   task automatic test_illegal();
      // Counter at idx4 is 10: a wrongful not-taken update would drop the MSB.
      issue(32'h8000_0010, 32'h20, 32'd5, 32'd5, 1'b0, 1'b0, 1'b1, 3'b010, 1'b1,
            mk(32'h8000_0014, 32'h8000_0014, 1'b0, 1'b1, 1'b1));
      idle(1);
      checks++;
      if (bht_taken !== 1'b1) begin
         failures++; $display("FAIL illegal_bht: got %b want 1", bht_taken);
      end
   endtask

   task automatic test_flush();
      res_ready = 1'b0;
      issue(32'h8000_0500, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1,
            mk(32'h8000_0504, 32'h8000_0504, 1'b0, 1'b1, 1'b0));
      // Flush the held result and a not-taken beq at idx4 in the same cycle.
      drive_req(32'h8000_0010, 32'h20, 32'd5, 32'd6, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0);
      flush = 1'b1;
      @(posedge clk); #1;
      end_req();
      void'(sb.pop_back());
      checks++;
      if (res_valid !== 1'b0) begin
         failures++; $display("FAIL flush_valid: got %b want 0", res_valid);
      end
      checks++;
      if (bht_taken !== 1'b1) begin
         failures++; $display("FAIL flush_bht: got %b want 1", bht_taken);
      end
      res_ready = 1'b1;
      issue(32'h8000_0010, 32'h20, 32'd5, 32'd6, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1,
            mk(32'h8000_0014, 32'h8000_0014, 1'b0, 1'b1, 1'b0));
      checks++;
      if (bht_taken !== 1'b0) begin
         failures++; $display("FAIL post_flush_update: got %b want 0", bht_taken);
      end
      idle(1);
   endtask

   task automatic test_compare();
      issue(32'h8000_0100, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1, 3'b110, 1'b0,
            mk(32'h8000_0104, 32'h8000_0104, 1'b0, 1'b0, 1'b0));
      issue(32'h8000_0100, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1, 3'b100, 1'b0,
            mk(32'h8000_0140, 32'h8000_0104, 1'b1, 1'b1, 1'b0));
      issue(32'h8000_0100, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1, 3'b111, 1'b1,
            mk(32'h8000_0140, 32'h8000_0104, 1'b1, 1'b0, 1'b0));
      issue(32'h8000_0100, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1, 3'b101, 1'b1,
            mk(32'h8000_0104, 32'h8000_0104, 1'b0, 1'b1, 1'b0));
      issue(32'h8000_0100, 32'h40, 32'd7, 32'd7, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0,
            mk(32'h8000_0104, 32'h8000_0104, 1'b0, 1'b0, 1'b0));
      issue(32'h8000_0100, 32'h42, 32'd7, 32'd7, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1,
            mk(32'h8000_0142, 32'h8000_0104, 1'b1, 1'b0, 1'b1));
      idle(1);
   endtask

   task automatic test_jumps();
      issue(32'h8000_0200, 32'h0, 32'h8000_1003, 32'h0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0,
            mk(32'h8000_1002, 32'h8000_0204, 1'b1, 1'b1, 1'b1));
      issue(32'h8000_0200, 32'h11, 32'h8000_1000, 32'h0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b1,
            mk(32'h8000_1010, 32'h8000_0204, 1'b1, 1'b1, 1'b0));
      issue(32'hFFFF_FFF0, 32'h20, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0,
            mk(32'h0000_0010, 32'hFFFF_FFF4, 1'b1, 1'b1, 1'b0));
      issue(32'h8000_0600, 32'h20, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1,
            mk(32'h8000_0604, 32'h8000_0604, 1'b0, 1'b1, 1'b0));
      issue(32'h8000_0600, 32'h20, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0,
            mk(32'h8000_0604, 32'h8000_0604, 1'b0, 1'b0, 1'b0));
      idle(1);
   endtask

   task automatic test_back_to_back();
      res_ready = 1'b0;
      issue(32'h8000_0300, 32'h8, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0,
            mk(32'h8000_0308, 32'h8000_0304, 1'b1, 1'b1, 1'b0));
      drive_req(32'h8000_0400, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (bru_ready_o !== 1'b0 || res_valid !== 1'b1 || next_pc !== 32'h8000_0308 ||
             link !== 32'h8000_0304 || taken !== 1'b1) begin
            failures++;
            $display("FAIL stall_hold_%0d: ready=%b valid=%b npc=%h link=%h t=%b, want 0 1 80000308 80000304 1",
                     i, bru_ready_o, res_valid, next_pc, link, taken);
         end
         @(posedge clk); #1;
      end
      res_ready = 1'b1;
      sb.push_back(mk(32'h8000_0404, 32'h8000_0404, 1'b0, 1'b0, 1'b0));
      @(posedge clk); #1;
      end_req();
      idle(2);
   endtask

   task automatic test_mid_reset();
      ifu_pc = 32'h8000_0020;
      issue(32'h8000_0020, 32'h4, 32'd1, 32'd1, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0,
            mk(32'h8000_0024, 32'h8000_0024, 1'b1, 1'b1, 1'b0));
      issue(32'h8000_0020, 32'h4, 32'd1, 32'd1, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1,
            mk(32'h8000_0024, 32'h8000_0024, 1'b1, 1'b0, 1'b0));
      idle(1);
      res_ready = 1'b0;
      issue(32'h8000_0020, 32'h4, 32'd1, 32'd1, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1,
            mk(32'h8000_0024, 32'h8000_0024, 1'b1, 1'b0, 1'b0));
      checks++;
      if (bht_taken !== 1'b1 || res_valid !== 1'b1) begin
         failures++;
         $display("FAIL pre_reset: bht=%b valid=%b want 1 1", bht_taken, res_valid);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      void'(sb.pop_back());
      checks++;
      if (res_valid !== 1'b0 || next_pc !== 32'h0 || bht_taken !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset: valid=%b npc=%h bht=%b want 0 00000000 0",
                  res_valid, next_pc, bht_taken);
      end
      res_ready = 1'b1;
      idle(1);
   endtask

   initial begin
      flush = 1'b0;
      test_reset();
      test_beq_first();
      test_saturate();
      test_illegal();
      test_flush();
      test_compare();
      test_jumps();
      test_back_to_back();
      test_mid_reset();
      idle(2);
      checks++;
      if (sb.size() != 0) begin
         failures++; $display("FAIL drain: %0d results never produced, want 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
